mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   MEM pipeline stage of the AArch64 core: takes the EX/MEM register output, drives the data bus (dreq/dresp),
//   aligns store data/strobes, extracts and extends load data, and emits memory_data_t to the Mem/Wr register.
//   Raises mem_stall while a bus access is outstanding; hazard unit uses it to freeze upstream and bubble Mem/Wr.
// PARAMETERS
//   ADDR_W   64          address width (matches common::addr_t)
//   DATA_W   64          data bus width; must be 64
//   STRB_W   DATA_W/8    byte-strobe width
// PORTS
//   clk         in   1        clock, rising edge; the only clock
//   rst         in   1        reset, synchronous, active-high
//   dataE       in   struct   execute_data_t: valid, mem_rd, mem_wr, size[1:0], sext, addr, wdata, dst, wb ctl
//   freeze      in   1        downstream/hazard freeze; result must be held, not re-issued
//   dreq        out  struct   dbus_req_t: valid, addr, size, strobe[STRB_W], data
//   dresp       in   struct   dbus_resp_t: addr_ok, data_ok, data
//   dataM       out  struct   memory_data_t to Mem/Wr register
//   mem_stall   out  1        access in flight, no valid result yet
//   mem_misalign out 1        misaligned access flagged (0 when MEM_MISALIGN_CHECK_EN undefined)
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE, dreq.valid=0, dataM.valid=0, mem_stall=0, hold buffer cleared.
//   States: IDLE, REQ (dreq.valid=1, held stable until data_ok), HOLD (result buffered while freeze=1).
//   IDLE: dataE.valid & (mem_rd|mem_wr) -> REQ same cycle (dreq.valid combinational from dataE, mem_stall=1).
//     Non-memory valid op: dataM = dataE fields, result = ALU value, zero latency, no bus activity.
//   REQ: dreq fields must not change while valid; on data_ok: freeze=0 -> dataM.valid=1 that cycle, -> IDLE;
//     freeze=1 -> capture result into hold buffer, -> HOLD, mem_stall=0. addr_ok without data_ok: remain in REQ.
//   HOLD: dataM driven from buffer; dreq.valid=0; leave to IDLE on first cycle freeze=0. No re-issue.
//   Minimum load/store latency: 1 cycle when data_ok returns in issue cycle (combinational pass-through).
//   Size encoding: 0=1B,1=2B,2=4B,3=8B. off=addr[2:0].
//     strobe = ((1<<(1<<size))-1) << off; store data = wdata << (8*off); load=0 strobe.
//     Load: raw = dresp.data >> (8*off), truncate to size; sext=1 sign-extends from top bit, else zero-extends to 64.
//   Store result: dataM.valid=1, no register write unless ctl requests (e.g. post-index base writeback).
//   rst in REQ/HOLD: abandon access, dreq.valid=0 next cycle; bus-side late data_ok ignored until a new request.
//   data_ok while IDLE (stale): ignored. dataE.valid=0: dataM.valid=0, no request.
// CONFIGURATION
//   MEM_MISALIGN_CHECK_EN defined: addr not aligned to size -> no bus request, mem_misalign=1,
//     dataM.valid=1 with exception flag set and register write suppressed, zero latency.
//   Undefined: no check; misaligned access issued as-is (bus behaviour unspecified); mem_misalign tied 0.
// STRUCTURE
//   pipes package: execute_data_t, memory_data_t (add exc flag field), mem_state_e enum.
//   common package: dbus_req_t, dbus_resp_t, msize_t, addr_t, word_t.
//   Sub-module mem_align: pure combinational strobe/shift/extend logic (store align + load extract),
//   shared with any future cache-side use; FSM and hold buffer remain in mem_access_stage.
// TESTING
//   LDRB addr=0x1003, sext=1, data_ok after 3 cycles, dresp.data=0x00000000_80000000 -> strobe 0, mem_stall 3 cycles,
//     result=0xFFFF_FFFF_FFFF_FF80, dataM.valid 1 cycle.
//   STRH addr=0x1006, wdata=0xBEEF -> strobe=8'hC0, dreq.data=0xBEEF_0000_0000_0000, dreq stable until data_ok.
//   data_ok with freeze=1 for 2 cycles -> HOLD, no second dreq.valid, dataM matches buffered value on release.
//   rst asserted in REQ -> dreq.valid=0 and dataM.valid=0 next cycle; subsequent stale data_ok ignored.
//   ADD (no mem) valid -> dataM.valid same cycle, mem_stall=0, dreq.valid=0.
//   MEM_MISALIGN_CHECK_EN: LDR X addr=0x1004 -> mem_misalign=1, no dreq.valid, exc flag set; undefined: issued.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared types for the MEM pipeline stage.
//   Bus side       : addr_t, word_t, msize_t, dbus_req_t, dbus_resp_t
//   Pipeline side  : execute_data_t (EX/MEM payload), memory_data_t (to Mem/Wr),
//                    mem_state_e (stage FSM states)
//   Helper         : is_misaligned() - size/offset alignment test, used when
//                    MEM_MISALIGN_CHECK_EN is defined.
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  // Access size: 0=1B, 1=2B, 2=4B, 3=8B
  typedef logic [1:0]        msize_t;

  typedef struct packed {
    logic              valid;
    addr_t             addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    word_t             data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic       valid;
    logic       mem_rd;
    logic       mem_wr;
    msize_t     size;
    logic       sext;
    addr_t      addr;
    word_t      wdata;
    word_t      alu_res;   // ALU value; also base-writeback value for stores
    logic [4:0] dst;
    logic       regwrite;
  } execute_data_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [4:0] dst;
    word_t      result;
    logic       exc;       // misaligned-access exception
  } memory_data_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic is_misaligned(input msize_t size, input logic [2:0] off);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = off[0];
      2'd2:    r = |off[1:0];
      2'd3:    r = |off;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_align.sv
// -----------------------------------------------------------------------------
// mem_access_stage_align
// Pure combinational data-path helper: store strobe/data alignment and load
// data extraction with sign/zero extension.
//   i_size     access size (0=1B .. 3=8B)
//   i_off      byte offset within the doubleword (addr[2:0])
//   i_sext     sign-extend loaded value
//   i_is_store strobes are only generated for stores
//   i_wdata    register store data (right-justified)
//   i_rdata    raw 64-bit bus read data
//   o_strobe   byte strobes for the bus
//   o_wdata    store data shifted to its byte lanes
//   o_rdata    extracted, extended load value
// -----------------------------------------------------------------------------
module mem_access_stage_align
  import mem_access_stage_pkg::*;
(
  input  msize_t            i_size,
  input  logic [2:0]        i_off,
  input  logic              i_sext,
  input  logic              i_is_store,
  input  word_t             i_wdata,
  input  word_t             i_rdata,
  output logic [STRB_W-1:0] o_strobe,
  output word_t             o_wdata,
  output word_t             o_rdata
);

  logic [STRB_W-1:0] w_mask;
  logic [5:0]        w_shamt;
  word_t             w_raw;

  assign w_shamt = {i_off, 3'b000};

  // Unshifted byte-lane mask for the access size.
  always_comb begin
    case (i_size)
      2'd0:    w_mask = 8'h01;
      2'd1:    w_mask = 8'h03;
      2'd2:    w_mask = 8'h0F;
      2'd3:    w_mask = 8'hFF;
      default: w_mask = 8'hFF;
    endcase
  end

  assign o_strobe = i_is_store ? (w_mask << i_off) : 8'h00;
  assign o_wdata  = i_wdata << w_shamt;
  assign w_raw    = i_rdata >> w_shamt;

  // Truncate the shifted read data to the access size and extend to 64 bits.
  always_comb begin
    case (i_size)
      2'd0:    o_rdata = {{56{i_sext & w_raw[7]}},  w_raw[7:0]};
      2'd1:    o_rdata = {{48{i_sext & w_raw[15]}}, w_raw[15:0]};
      2'd2:    o_rdata = {{32{i_sext & w_raw[31]}}, w_raw[31:0]};
      2'd3:    o_rdata = w_raw;
      default: o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage: drives the data bus for loads/stores, aligns store data, extracts
// load data and presents the result to the Mem/Wr register.
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_data_e       EX/MEM payload (execute_data_t)
//   i_freeze       downstream freeze; a finished result is held, never re-issued
//   o_dreq         data bus request (dbus_req_t)
//   i_dresp        data bus response (dbus_resp_t)
//   o_data_m       result to Mem/Wr (memory_data_t)
//   o_mem_stall    access in flight without a result yet
//   o_mem_misalign misaligned access flagged
// Build option: MEM_MISALIGN_CHECK_EN - when defined, misaligned accesses are
// not issued; they complete at once with the exception flag set and register
// write suppressed. When undefined they are issued as-is and o_mem_misalign=0.
// -----------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  execute_data_t i_data_e,
  input  logic          i_freeze,
  output dbus_req_t     o_dreq,
  input  dbus_resp_t    i_dresp,
  output memory_data_t  o_data_m,
  output logic          o_mem_stall,
  output logic          o_mem_misalign
);

  mem_state_e    r_state;
  mem_state_e    w_state_nxt;
  execute_data_t r_op;     // request captured on entry to REQ, keeps dreq stable
  memory_data_t  r_hold;   // result buffered while frozen

  execute_data_t     w_op;
  logic              w_is_mem;
  logic              w_misalign;
  logic              w_issue;
  logic              w_done;
  logic [STRB_W-1:0] w_strobe;
  word_t             w_wdata_al;
  word_t             w_load;
  memory_data_t      w_result;
  logic              w_unused_ok;

  // In IDLE the request comes straight from EX so a same-cycle data_ok can complete.
  assign w_op     = (r_state == ST_REQ) ? r_op : i_data_e;
  assign w_is_mem = i_data_e.valid & (i_data_e.mem_rd | i_data_e.mem_wr);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = w_is_mem & is_misaligned(i_data_e.size, i_data_e.addr[2:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = (r_state == ST_IDLE) & w_is_mem & ~w_misalign;
  // data_ok counts only for a request presented this cycle; stale ones fall through.
  assign w_done  = (w_issue | (r_state == ST_REQ)) & i_dresp.data_ok;

  mem_access_stage_align u_align (
    .i_size     (w_op.size),
    .i_off      (w_op.addr[2:0]),
    .i_sext     (w_op.sext),
    .i_is_store (w_op.mem_wr),
    .i_wdata    (w_op.wdata),
    .i_rdata    (i_dresp.data),
    .o_strobe   (w_strobe),
    .o_wdata    (w_wdata_al),
    .o_rdata    (w_load)
  );

  // Completed-access result: loads return bus data, stores return the ALU value.
  always_comb begin
    w_result          = '0;
    w_result.valid    = 1'b1;
    w_result.regwrite = w_op.regwrite;
    w_result.dst      = w_op.dst;
    w_result.exc      = 1'b0;
    if (w_op.mem_rd) begin
      w_result.result = w_load;
    end else begin
      w_result.result = w_op.alu_res;
    end
  end

  assign w_unused_ok = &{1'b0, i_dresp.addr_ok, w_op.valid};

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture and hold buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op   <= '0;
      r_hold <= '0;
    end else begin
      if (w_issue) begin
        r_op <= i_data_e;
      end else begin
        r_op <= r_op;
      end
      if (w_done & i_freeze) begin
        r_hold <= w_result;
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          if (w_done) begin
            w_state_nxt = i_freeze ? ST_HOLD : ST_IDLE;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_done) begin
          w_state_nxt = i_freeze ? ST_HOLD : ST_IDLE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (i_freeze) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_dreq         = '0;
    o_data_m       = '0;
    o_mem_stall    = 1'b0;
    o_mem_misalign = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_misalign) begin
          // Faulting address reported in the result field.
          o_mem_misalign    = 1'b1;
          o_data_m.valid    = 1'b1;
          o_data_m.regwrite = 1'b0;
          o_data_m.dst      = i_data_e.dst;
          o_data_m.result   = i_data_e.addr;
          o_data_m.exc      = 1'b1;
        end else if (w_issue) begin
          o_dreq.valid  = 1'b1;
          o_dreq.addr   = w_op.addr;
          o_dreq.size   = w_op.size;
          o_dreq.strobe = w_strobe;
          o_dreq.data   = w_wdata_al;
          if (w_done) begin
            o_data_m = w_result;
          end else begin
            o_mem_stall = 1'b1;
          end
        end else if (i_data_e.valid) begin
          o_data_m.valid    = 1'b1;
          o_data_m.regwrite = i_data_e.regwrite;
          o_data_m.dst      = i_data_e.dst;
          o_data_m.result   = i_data_e.alu_res;
          o_data_m.exc      = 1'b0;
        end else begin
          o_data_m.valid = 1'b0;
        end
      end
      ST_REQ: begin
        o_dreq.valid  = 1'b1;
        o_dreq.addr   = w_op.addr;
        o_dreq.size   = w_op.size;
        o_dreq.strobe = w_strobe;
        o_dreq.data   = w_wdata_al;
        if (w_done) begin
          o_data_m = w_result;
        end else begin
          o_mem_stall = 1'b1;
        end
      end
      ST_HOLD: begin
        o_data_m = r_hold;
      end
      default: begin
        o_data_m = '0;
      end
    endcase
  end

endmodule
